// File: rtl/wisc_pkg.sv
// Shared encodings for the WISC decode-stage redirect logic.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package wisc_pkg;

  // Branch opcodes on br_op; bit 2 set means "this is a conditional branch".
  localparam logic [2:0] BR_BEQZ = 3'b100;
  localparam logic [2:0] BR_BNEZ = 3'b101;
  localparam logic [2:0] BR_BLTZ = 3'b110;
  localparam logic [2:0] BR_BGEZ = 3'b111;

  // Redirect source codes reported on redir_sel.
  localparam logic [2:0] SEL_NONE  = 3'd0;
  localparam logic [2:0] SEL_JDISP = 3'd1;
  localparam logic [2:0] SEL_BR    = 3'd2;
  localparam logic [2:0] SEL_JR    = 3'd3;
  localparam logic [2:0] SEL_SIIC  = 3'd4;
  localparam logic [2:0] SEL_RTI   = 3'd5;

  // Operand forwarding sources.
  localparam logic [1:0] FWD_RS  = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_EX  = 2'd3;

  // Register-jump wait sequencer.
  typedef enum logic [1:0] {
    JR_IDLE = 2'd0,
    JR_WAIT = 2'd1,
    JR_LOAD = 2'd2
  } jr_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Latency: count visible the cycle after inc.
// Backpressure: none; sticks at all-ones.
// Ports: clk, rst (async active-low), inc, clr, cnt.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/redirect_unit.sv
// Decode-stage control-flow resolver: branches, jumps, JR/JALR, SIIC, RTI.
// Latency: redirect valid one cycle after resolve; JR after JR_LATENCY wait + load.
// Backpressure: redirect held until redir_ready; only SIIC/RTI overwrite a held one.
// Ports: decode controls (valid_d, stall_d, npc_d, br_op, jump, jump_reg, siic,
//   rti, imm, disp), operand sources (fwd_sel, rs/wb/mem/ex_data), alu_target,
//   epc, redir_ready, clr_cnt; outputs redir_valid/pc/sel, flush_fd, jr_busy,
//   br_cnt, taken_cnt.
module redirect_unit
  import wisc_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter int               JR_LATENCY = 1,
  parameter int               CNT_W      = 16,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 16'h0002
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_d,
  input  logic             stall_d,
  input  logic [WIDTH-1:0] npc_d,
  input  logic [2:0]       br_op,
  input  logic             jump,
  input  logic             jump_reg,
  input  logic             siic,
  input  logic             rti,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] disp,
  input  logic [1:0]       fwd_sel,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [WIDTH-1:0] mem_data,
  input  logic [WIDTH-1:0] ex_data,
  input  logic [WIDTH-1:0] alu_target,
  input  logic [WIDTH-1:0] epc,
  input  logic             redir_ready,
  input  logic             clr_cnt,
  output logic             redir_valid,
  output logic [WIDTH-1:0] redir_pc,
  output logic [2:0]       redir_sel,
  output logic             flush_fd,
  output logic             jr_busy,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  // Wait counter is sized for the legal latency range 1..4.
  localparam logic [1:0] JR_INIT = 2'(JR_LATENCY - 1);

  jr_state_e        state_q, state_d;
  logic [1:0]       wait_q, wait_d;
  logic             load_jr;

  logic [WIDTH-1:0] op;
  logic             taken;
  logic             go;
  logic             any_exc;
  logic             nonexc_req;
  logic             jr_req;
  logic             slot_free;
  logic             load_dec;
  logic             jr_start;
  logic [WIDTH-1:0] dec_pc;
  logic [2:0]       dec_sel;

  // Operand forwarding mux.
  always_comb begin
    op = rs_data;
    case (fwd_sel)
      FWD_WB:  op = wb_data;
      FWD_MEM: op = mem_data;
      FWD_EX:  op = ex_data;
      default: op = rs_data;
    endcase
  end

  // Branch condition; non-branch encodings never resolve taken.
  always_comb begin
    taken = 1'b0;
    case (br_op)
      BR_BEQZ: taken = (op == '0);
      BR_BNEZ: taken = (op != '0);
      BR_BLTZ: taken = op[WIDTH-1];
      BR_BGEZ: taken = ~op[WIDTH-1];
      default: taken = 1'b0;
    endcase
  end

  assign go         = valid_d & ~stall_d & (state_q == JR_IDLE);
  assign any_exc    = siic | rti;
  assign nonexc_req = taken | (jump & ~jump_reg);
  assign jr_req     = jump & jump_reg;
  assign slot_free  = ~redir_valid | redir_ready;

  // Exceptions always win the request register; everything else waits for a
  // free slot (empty, or being accepted this very edge) and is dropped otherwise.
  assign load_dec = go & (any_exc | (nonexc_req & slot_free));
  assign jr_start = go & ~any_exc & ~taken & jr_req & slot_free;

  // Priority: siic > rti > taken branch > immediate jump.
  always_comb begin
    dec_pc  = npc_d + disp;
    dec_sel = SEL_JDISP;
    if (siic) begin
      dec_pc  = EXC_VECTOR;
      dec_sel = SEL_SIIC;
    end else if (rti) begin
      dec_pc  = epc;
      dec_sel = SEL_RTI;
    end else if (taken) begin
      dec_pc  = npc_d + imm;
      dec_sel = SEL_BR;
    end
  end

  // Kill the wrong-path fetch in the resolve cycle, not a cycle later.
  assign flush_fd = (go & (any_exc | nonexc_req | jr_req)) | jr_busy | redir_valid;

  // JR sequencer: WAIT counts non-stalled cycles until alu_target is valid,
  // LOAD captures it into the request register on its closing edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= JR_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    load_jr = 1'b0;
    jr_busy = (state_q == JR_WAIT);
    case (state_q)
      JR_IDLE: begin
        if (jr_start) begin
          state_d = JR_WAIT;
          wait_d  = JR_INIT;
        end
      end
      JR_WAIT: begin
        if (!stall_d) begin
          if (wait_q == 2'd0) state_d = JR_LOAD;
          else                wait_d  = wait_q - 2'd1;
        end
      end
      JR_LOAD: begin
        load_jr = 1'b1;
        state_d = JR_IDLE;
      end
      default: state_d = JR_IDLE;
    endcase
  end

  // Held request register. The slot is always free in LOAD because a JR only
  // starts with a free slot and nothing else can load while the wait runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      redir_sel   <= SEL_NONE;
    end else if (load_jr) begin
      redir_valid <= 1'b1;
      redir_pc    <= alu_target;
      redir_sel   <= SEL_JR;
    end else if (load_dec) begin
      redir_valid <= 1'b1;
      redir_pc    <= dec_pc;
      redir_sel   <= dec_sel;
    end else if (redir_valid && redir_ready) begin
      redir_valid <= 1'b0;
      redir_sel   <= SEL_NONE;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk (clk),
    .rst (rst),
    .inc (go & br_op[2]),
    .clr (clr_cnt),
    .cnt (br_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk (clk),
    .rst (rst),
    .inc (go & taken),
    .clr (clr_cnt),
    .cnt (taken_cnt)
  );

endmodule
